// File: rtl/phasor_bank.sv
// phasor_bank: multi-channel phase accumulator bank.
// A sample_tick starts a sweep that updates one channel per enabled cycle.
// Each channel update produces one registered result carrying the
// wavetable address, the interpolation fraction and a wrap flag for that
// channel. Per-channel increments can be rewritten at any time.
// Per-channel hard-sync requests are held pending until the channel is next
// processed.
module phasor_bank #(
  parameter int DW  = 32,
  parameter int AW  = 12,
  parameter int NCH = 8,
  localparam int IW = DW - AW,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          En,
  input  logic          sample_tick,
  input  logic          inc_we,
  input  logic [CW-1:0] inc_ch,
  input  logic [DW-1:0] inc_data,
  input  logic [NCH-1:0] sync_req,
  input  logic [DW-1:0] fm_input,
  input  logic [DW-1:0] phase_offset,
  output logic [CW-1:0] req_ch,
  output logic          busy,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [AW-1:0] wavetable_addr,
  output logic [IW-1:0] interp,
  output logic          wrap,
  output logic          done,
  output logic          overrun
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] req_ch_reg, req_ch_next;
  logic          process, last_ch, tick_drop;

  // Per-channel state, gathered into arrays for the shared datapath mux
  logic [DW-1:0] phase_arr [NCH];
  logic [DW-1:0] inc_arr   [NCH];
  logic          pend_arr  [NCH];

  logic [DW-1:0] cur_phase, cur_inc, phase_addr, new_phase;
  logic          cur_sync, carry;
  logic [DW+1:0] sum;

  logic          out_valid_reg, done_reg, wrap_reg, overrun_reg;
  logic [CW-1:0] out_ch_reg;
  logic [AW-1:0] addr_reg;
  logic [IW-1:0] interp_reg;

  assign last_ch = (req_ch_reg == CW'(NCH - 1));

  // FSM state and channel pointer register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      req_ch_reg <= '0;
    end else begin
      state_reg  <= state_next;
      req_ch_reg <= req_ch_next;
    end
  end

  // Next-state logic; a tick is only accepted in IDLE outside the done cycle
  always_comb begin
    state_next  = state_reg;
    req_ch_next = req_ch_reg;
    process     = 1'b0;
    tick_drop   = 1'b0;
    if (En) begin
      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            if (done_reg) begin
              tick_drop = 1'b1;
            end else begin
              state_next  = SWEEP;
              req_ch_next = '0;
            end
          end
        end
        SWEEP: begin
          process   = 1'b1;
          tick_drop = sample_tick;
          if (last_ch) begin
            state_next  = IDLE;
            req_ch_next = '0;
          end else begin
            req_ch_next = req_ch_reg + CW'(1);
          end
        end
        default: begin
          state_next  = IDLE;
          req_ch_next = '0;
        end
      endcase
    end
  end

  // Shared datapath for the channel being processed. The sum is two bits
  // wider than the phase because three DW-bit terms are added together.
  assign cur_phase  = phase_arr[req_ch_reg];
  assign cur_inc    = inc_arr[req_ch_reg];
  assign cur_sync   = pend_arr[req_ch_reg];
  assign sum        = {2'b00, cur_phase} + {2'b00, cur_inc} + {2'b00, fm_input};
  assign new_phase  = sum[DW-1:0];
  assign carry      = |sum[DW+1:DW];
  assign phase_addr = cur_phase + phase_offset;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] phase_reg, inc_reg;
    logic          sync_pend_reg;
    logic          sel, inc_sel;

    // Out-of-range inc_ch values match no channel and are dropped
    assign sel     = process && (req_ch_reg == CW'(gi));
    assign inc_sel = inc_we && (inc_ch == CW'(gi));

    // Channel registers; increment writes bypass En, sync set beats consume
    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        phase_reg     <= '0;
        inc_reg       <= '0;
        sync_pend_reg <= 1'b0;
      end else begin
        if (inc_sel) inc_reg <= inc_data;
        if (sel) phase_reg <= sync_pend_reg ? '0 : new_phase;
        if (En) sync_pend_reg <= (sync_pend_reg & ~sel) | sync_req[gi];
      end
    end

    assign phase_arr[gi] = phase_reg;
    assign inc_arr[gi]   = inc_reg;
    assign pend_arr[gi]  = sync_pend_reg;
  end

  // Result registers; frozen while En is low so a paused sweep loses nothing
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      out_ch_reg    <= '0;
      addr_reg      <= '0;
      interp_reg    <= '0;
      wrap_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (En) begin
      out_valid_reg <= process;
      done_reg      <= process && last_ch;
      if (process) begin
        out_ch_reg <= req_ch_reg;
        addr_reg   <= phase_addr[DW-1:IW];
        interp_reg <= phase_addr[IW-1:0];
        wrap_reg   <= carry & ~cur_sync;
      end
      if (tick_drop) overrun_reg <= 1'b1;
    end
  end

  assign req_ch         = req_ch_reg;
  assign busy           = (state_reg == SWEEP);
  assign out_valid      = out_valid_reg & En;
  assign done           = done_reg & En;
  assign out_ch         = out_ch_reg;
  assign wavetable_addr = addr_reg;
  assign interp         = interp_reg;
  assign wrap           = wrap_reg;
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_phasor_bank.sv
// tb_phasor_bank: directed, table-driven bench for phasor_bank (NCH=4),
// plus a small NCH=3 instance for out-of-range increment writes.
module tb_phasor_bank;

  logic        clk = 1'b0;
  logic        Reset_n, En, sample_tick, inc_we;
  logic [1:0]  inc_ch;
  logic [31:0] inc_data;
  logic [3:0]  sync_req;
  logic [31:0] fm_input, phase_offset;
  logic [1:0]  req_ch, out_ch;
  logic        busy, out_valid, wrap, done, overrun;
  logic [11:0] wavetable_addr;
  logic [19:0] interp;

  logic [1:0]  req_ch3, out_ch3;
  logic        busy3, out_valid3, wrap3, done3, overrun3;
  logic [11:0] wavetable_addr3;
  logic [19:0] interp3;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] addr;
    logic [19:0] interp;
    logic        wrap;
    logic        done;
  } res_t;

  typedef struct {
    logic [31:0] fm;
    logic [31:0] off;
    logic [11:0] addr;
    logic [19:0] interp;
    logic        wrap;
  } vec_t;

  res_t        q[$];
  res_t        q3[$];
  vec_t        vt [20];
  logic [11:0] sync_exp [7];
  int          n_vec = 0;
  int          n_bad = 0;
  int          stray = 0;
  int          base = 0;
  logic        use_tab = 1'b0;
  logic [31:0] fm_man = '0;
  logic [31:0] off_man = '0;

  always #5 clk = ~clk;

  phasor_bank #(.DW(32), .AW(12), .NCH(4)) u_dut (
    .Clk(clk), .Reset_n(Reset_n), .En(En), .sample_tick(sample_tick),
    .inc_we(inc_we), .inc_ch(inc_ch), .inc_data(inc_data), .sync_req(sync_req),
    .fm_input(fm_input), .phase_offset(phase_offset), .req_ch(req_ch),
    .busy(busy), .out_valid(out_valid), .out_ch(out_ch),
    .wavetable_addr(wavetable_addr), .interp(interp), .wrap(wrap),
    .done(done), .overrun(overrun)
  );

  phasor_bank #(.DW(32), .AW(12), .NCH(3)) u_dut3 (
    .Clk(clk), .Reset_n(Reset_n), .En(En), .sample_tick(sample_tick),
    .inc_we(inc_we), .inc_ch(inc_ch), .inc_data(inc_data), .sync_req(sync_req[2:0]),
    .fm_input(fm_input), .phase_offset(phase_offset), .req_ch(req_ch3),
    .busy(busy3), .out_valid(out_valid3), .out_ch(out_ch3),
    .wavetable_addr(wavetable_addr3), .interp(interp3), .wrap(wrap3),
    .done(done3), .overrun(overrun3)
  );

  // Per-channel FM/offset come from the vector table while it is in use
  always_comb begin
    fm_input     = fm_man;
    phase_offset = off_man;
    if (use_tab) begin
      fm_input     = vt[base + int'(req_ch)].fm;
      phase_offset = vt[base + int'(req_ch)].off;
    end
  end

  // Result monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q.push_back('{out_ch, wavetable_addr, interp, wrap, done});
      $display("result ch=%0d addr=0x%03h interp=0x%05h wrap=%0b done=%0b",
               out_ch, wavetable_addr, interp, wrap, done);
    end
    if (out_valid3 === 1'b1) q3.push_back('{out_ch3, wavetable_addr3, interp3, wrap3, done3});
    if ((done === 1'b1 && out_valid !== 1'b1) || (done3 === 1'b1 && out_valid3 !== 1'b1)) stray++;
    if (En === 1'b0 && (out_valid === 1'b1 || done === 1'b1)) stray++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int idx, input logic [1:0] ch,
                         input logic [11:0] addr, input logic [19:0] ip,
                         input logic wr, input logic dn);
    res_t r;
    if (idx >= q.size()) begin
      chk({tag, " present"}, 64'(q.size()), 64'(idx + 1));
    end else begin
      r = q[idx];
      chk({tag, " ch"}, 64'(r.ch), 64'(ch));
      chk({tag, " addr"}, 64'(r.addr), 64'(addr));
      chk({tag, " interp"}, 64'(r.interp), 64'(ip));
      chk({tag, " wrap"}, 64'(r.wrap), 64'(wr));
      chk({tag, " done"}, 64'(r.done), 64'(dn));
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    cyc(2);
    Reset_n = 1'b1;
    cyc(1);
    q.delete();
    q3.delete();
  endtask

  task automatic wr_inc(input logic [1:0] ch, input logic [31:0] data);
    inc_we   = 1'b1;
    inc_ch   = ch;
    inc_data = data;
    cyc(1);
    inc_we   = 1'b0;
  endtask

  // One sweep: tick at cycle 0, optional stall/extra tick/sync/inc write,
  // ending on the first cycle a new tick must be accepted.
  task automatic sweep(input int stall_at, input int stall_len, input int tick2_at,
                       input logic [3:0] smask, input int sync_at,
                       input int incw_at, input logic [1:0] incw_ch,
                       input logic [31:0] incw_data);
    for (int c = 0; c < 6 + stall_len; c++) begin
      sample_tick = (c == 0) || (c == tick2_at);
      En          = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      sync_req    = (c == sync_at) ? smask : 4'b0000;
      inc_we      = (c == incw_at);
      inc_ch      = incw_ch;
      inc_data    = incw_data;
      cyc(1);
    end
    sample_tick = 1'b0;
    En          = 1'b1;
    sync_req    = '0;
    inc_we      = 1'b0;
  endtask

  task automatic plain_sweep();
    sweep(-1, 0, -1, 4'b0000, -1, -1, 2'd0, 32'd0);
  endtask

  initial begin
    // fm, offset, expected addr, interp, wrap; channel = index % 4
    vt[0]  = '{32'h0, 32'h0, 12'h000, 20'h0, 1'b0};
    vt[1]  = '{32'h0, 32'h0, 12'h000, 20'h0, 1'b0};
    vt[2]  = '{32'h0, 32'h0, 12'h000, 20'h0, 1'b0};
    vt[3]  = '{32'h0, 32'h0, 12'h000, 20'h0, 1'b0};
    vt[4]  = '{32'h0, 32'h0, 12'h100, 20'h0, 1'b0};
    vt[5]  = '{32'h0, 32'h0, 12'h200, 20'h0, 1'b0};
    vt[6]  = '{32'h0, 32'h0, 12'h300, 20'h0, 1'b0};
    vt[7]  = '{32'h0, 32'h0, 12'h400, 20'h0, 1'b0};
    vt[8]  = '{32'h0000_0001, 32'h0000_0123, 12'h200, 20'h00123, 1'b0};
    vt[9]  = '{32'h0000_0000, 32'h0008_0000, 12'h400, 20'h80000, 1'b0};
    vt[10] = '{32'hF000_0000, 32'hFFF0_0000, 12'h5FF, 20'h00000, 1'b1};
    vt[11] = '{32'h8000_0000, 32'h8000_0005, 12'h000, 20'h00005, 1'b1};
    vt[12] = '{32'h0, 32'h0, 12'h300, 20'h00001, 1'b0};
    vt[13] = '{32'h0, 32'h0, 12'h600, 20'h00000, 1'b0};
    vt[14] = '{32'h0, 32'h0, 12'h800, 20'h00000, 1'b0};
    vt[15] = '{32'h0, 32'h0, 12'h400, 20'h00000, 1'b0};
    vt[16] = '{32'hFFFF_FFFF, 32'h0, 12'h400, 20'h00001, 1'b1};
    vt[17] = '{32'hFFFF_FFFF, 32'h0, 12'h800, 20'h00000, 1'b1};
    vt[18] = '{32'h0000_0000, 32'h0, 12'hB00, 20'h00000, 1'b0};
    vt[19] = '{32'h0000_0000, 32'h0, 12'h800, 20'h00000, 1'b0};
    sync_exp[0] = 12'h003; sync_exp[1] = 12'h103; sync_exp[2] = 12'h203;
    sync_exp[3] = 12'h003; sync_exp[4] = 12'h103; sync_exp[5] = 12'h003;
    sync_exp[6] = 12'h003;

    Reset_n = 1'b0; En = 1'b1; sample_tick = 1'b0; inc_we = 1'b0;
    inc_ch = '0; inc_data = '0; sync_req = '0;

    // Reset state
    cyc(3);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst overrun", 64'(overrun), 64'd0);
    chk("rst addr", 64'(wavetable_addr), 64'd0);
    chk("rst req_ch", 64'(req_ch), 64'd0);
    Reset_n = 1'b1;
    cyc(1);

    // Table-driven sweeps
    for (int k = 0; k < 4; k++) wr_inc(k[1:0], 32'h1000_0000 * (k + 1));
    use_tab = 1'b1;
    for (int s = 0; s < 5; s++) begin
      base = s * 4;
      plain_sweep();
      chk($sformatf("S%0d count", s), 64'(q.size()), 64'd4);
      for (int k = 0; k < 4; k++)
        chk_res($sformatf("S%0d ch%0d", s, k), k, k[1:0], vt[s*4+k].addr,
                vt[s*4+k].interp, vt[s*4+k].wrap, k == 3);
      q.delete();
    end
    use_tab = 1'b0;
    base = 0;

    // Wrap on channel 0
    do_reset();
    wr_inc(2'd0, 32'h8000_0000);
    for (int s = 0; s < 3; s++) begin
      plain_sweep();
      chk_res($sformatf("wrap t%0d", s + 1), 0, 2'd0, (s == 1) ? 12'h800 : 12'h000,
              20'h0, s == 1, 1'b0);
      q.delete();
    end

    // Hard sync on channel 2, including set-wins on consume
    do_reset();
    wr_inc(2'd2, 32'h1000_0000);
    off_man = 32'h0030_0000;
    for (int s = 0; s < 7; s++) begin
      if (s == 4) begin
        sync_req = 4'b0100;
        cyc(1);
        sync_req = 4'b0000;
      end
      sweep(-1, 0, -1, 4'b0100, (s == 1) ? 4 : ((s == 4) ? 3 : -1), -1, 2'd0, 32'd0);
      chk($sformatf("sync s%0d count", s), 64'(q.size()), 64'd4);
      chk_res($sformatf("sync s%0d", s), 2, 2'd2, sync_exp[s], 20'h0, 1'b0, 1'b0);
      q.delete();
    end
    off_man = '0;

    // Overrun while busy, then an En stall mid-sweep
    do_reset();
    chk("ovr before", 64'(overrun), 64'd0);
    for (int k = 0; k < 4; k++) wr_inc(k[1:0], 32'h1000_0000 * (k + 1));
    sweep(-1, 0, 2, 4'b0000, -1, -1, 2'd0, 32'd0);
    chk("ovr busy count", 64'(q.size()), 64'd4);
    chk("ovr busy flag", 64'(overrun), 64'd1);
    q.delete();
    sweep(2, 3, -1, 4'b0000, -1, -1, 2'd0, 32'd0);
    chk("stall count", 64'(q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk_res($sformatf("stall ch%0d", k), k, k[1:0], 12'(12'h100 * (k + 1)), 20'h0, 1'b0, k == 3);
    q.delete();

    // Tick in the done cycle is dropped; tick on the next cycle is accepted
    do_reset();
    chk("ovr reset", 64'(overrun), 64'd0);
    sweep(-1, 0, 5, 4'b0000, -1, -1, 2'd0, 32'd0);
    chk("done-tick count", 64'(q.size()), 64'd4);
    chk("done-tick overrun", 64'(overrun), 64'd1);
    chk("done-tick busy", 64'(busy), 64'd0);
    q.delete();
    plain_sweep();
    chk("after-done count", 64'(q.size()), 64'd4);
    q.delete();

    // Increment write colliding with the channel being processed
    do_reset();
    wr_inc(2'd1, 32'h1000_0000);
    for (int s = 0; s < 4; s++) begin
      sweep(-1, 0, -1, 4'b0000, -1, (s == 1) ? 2 : -1, 2'd1, 32'h5000_0000);
      chk_res($sformatf("coll s%0d", s), 1, 2'd1,
              (s == 0) ? 12'h000 : (s == 1) ? 12'h100 : (s == 2) ? 12'h200 : 12'h700,
              20'h0, 1'b0, 1'b0);
      q.delete();
    end

    // Out-of-range increment channel on the three-channel instance
    do_reset();
    wr_inc(2'd3, 32'hFFFF_FFFF);
    wr_inc(2'd2, 32'h1000_0000);
    plain_sweep();
    plain_sweep();
    chk("nch3 count", 64'(q3.size()), 64'd6);
    for (int i = 0; i < 6 && i < q3.size(); i++) begin
      chk($sformatf("nch3 r%0d ch", i), 64'(q3[i].ch), 64'(i % 3));
      chk($sformatf("nch3 r%0d addr", i), 64'(q3[i].addr), (i == 5) ? 64'h100 : 64'h0);
      chk($sformatf("nch3 r%0d done", i), 64'(q3[i].done), 64'(i % 3 == 2));
    end

    // Reset in the middle of a sweep
    do_reset();
    for (int k = 0; k < 4; k++) wr_inc(k[1:0], 32'h1000_0000 * (k + 1));
    plain_sweep();
    q.delete();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
    cyc(2);
    Reset_n = 1'b0;
    cyc(1);
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst out_ch", 64'(out_ch), 64'd0);
    chk("midrst addr", 64'(wavetable_addr), 64'd0);
    chk("midrst interp", 64'(interp), 64'd0);
    chk("midrst wrap", 64'(wrap), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst req_ch", 64'(req_ch), 64'd0);
    Reset_n = 1'b1;
    cyc(6);
    chk("midrst results", 64'(q.size()), 64'd2);
    chk("midrst idle", 64'(busy), 64'd0);
    q.delete();
    for (int s = 0; s < 2; s++) begin
      plain_sweep();
      chk($sformatf("postrst s%0d count", s), 64'(q.size()), 64'd4);
      for (int k = 0; k < 4; k++)
        chk_res($sformatf("postrst s%0d ch%0d", s, k), k, k[1:0], 12'h000, 20'h0, 1'b0, k == 3);
      q.delete();
    end

    chk("stray valid/done", 64'(stray), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
